// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler: MSB-first shift register, 2-bit byte index and
// running XOR checksum of every shifted-in byte.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [7:0]             in_data,
    output logic [IMEM_DATA_W-1:0] word,
    output logic [1:0]             idx,
    output logic [7:0]             csum
);

    logic [IMEM_DATA_W-1:0] word_q, word_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        csum_d = csum_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
            csum_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[IMEM_DATA_W-9:0], in_data};
            idx_d  = idx_q + 2'd1;
            csum_d = csum_q ^ in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            csum_q <= csum_d;
        end
    end

    assign word = word_q;
    assign idx  = idx_q;
    assign csum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (LEN, 4*N payload bytes, XOR CSUM) into imem
// words from address 0, holding the core via busy while a load runs.
//
// state | meaning
// IDLE  | waiting for start
// LEN   | receiving the word-count byte
// BYTES | receiving payload bytes of the current word
// WRITE | one-cycle imem write of the assembled word
// CSUM  | receiving the checksum byte
// DONE  | one-cycle completion pulse, back to IDLE
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    ld_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    remaining_q, remaining_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic               xfer;
    logic               len_bad;
    logic               asm_clr;
    logic               asm_shift;
    logic [DATA_W-1:0]  asm_word;
    logic [1:0]         asm_idx;
    logic [7:0]         asm_csum;

    assign xfer    = in_valid & in_ready;
    assign len_bad = int'(in_data) > DEPTH;

    imem_word_asm u_word_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (asm_clr),
        .shift_en (asm_shift),
        .in_data  (in_data),
        .word     (asm_word),
        .idx      (asm_idx),
        .csum     (asm_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !abort) state_d = ST_LEN;
            ST_LEN:   if (abort) state_d = ST_DONE;
                      else if (xfer) state_d = len_bad ? ST_DONE : ST_BYTES;
            ST_BYTES: if (abort) state_d = ST_DONE;
                      else if (xfer && asm_idx == 2'd3) state_d = ST_WRITE;
            ST_WRITE: if (abort) state_d = ST_DONE;
                      else if (remaining_q == (ADDR_W+1)'(1)) state_d = ST_CSUM;
                      else state_d = ST_BYTES;
            ST_CSUM:  if (abort || xfer) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        asm_clr     = 1'b0;
        asm_shift   = 1'b0;
        if (busy && abort) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !abort) begin
                    err_d   = 1'b0;
                    addr_d  = '0;
                    asm_clr = 1'b1;
                end
                ST_LEN: if (xfer) begin
                    remaining_d = (in_data == 8'd0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(in_data);
                    err_d       = len_bad;
                end
                ST_BYTES: asm_shift = xfer;
                ST_WRITE: begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = asm_word;
                end
                ST_CSUM: if (xfer) err_d = (in_data != asm_csum);
                default: ;
            endcase
        end
    end

    // Outside WRITE the write port shows the last word actually written.
    always_comb begin
        in_ready = (state_q == ST_LEN) || (state_q == ST_BYTES) || (state_q == ST_CSUM);
        busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done     = (state_q == ST_DONE);
        wr_en    = (state_q == ST_WRITE) && !abort;
        wr_addr  = wr_en ? addr_q : wr_addr_q;
        wr_data  = wr_en ? asm_word : wr_data_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame-level model of expected writes and error,
// checked on every cycle by a single compare process.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, busy, done, err;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         w;
    logic        exp_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [5:0]  log_a [0:127];
    logic [31:0] log_d [0:127];
    int          log_n;
    logic [31:0] frame_w [0:63];
    int          last_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ctrl", {27'b0, in_ready, wr_en, busy, done, err}, 32'd0);
            check("reset_wr_addr", {26'b0, wr_addr}, 32'd0);
            check("reset_wr_data", wr_data, 32'd0);
        end else begin
            if (wr_en) begin
                if (log_n < 128) begin
                    log_a[log_n] = wr_addr;
                    log_d[log_n] = wr_data;
                end
                log_n++;
                check("in_ready_in_write", {31'b0, in_ready}, 32'd0);
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", {26'b0, wr_addr}, {26'b0, w.a});
                    check("wr_data", wr_data, w.d);
                end
            end
            if (done) begin
                check("done_err", {31'b0, err}, {31'b0, exp_err});
                check("done_busy", {31'b0, busy}, 32'd0);
                check("done_pending_writes", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    task automatic gap(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt;
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("in_ready_seen", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 1;
        @(negedge clk);
        while (!done && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        last_lat = cnt;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [7:0] len, input bit bad, input int max_gap);
        int         n;
        logic [7:0] x;
        log_n = 0;
        pulse_start();
        if (int'(len) > 64) begin
            exp_err = 1'b1;
            send_byte(len);
        end else begin
            n = (len == 8'd0) ? 64 : int'(len);
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(wr_t'{a: 6'(i), d: frame_w[i]});
                x = x ^ frame_w[i][31:24] ^ frame_w[i][23:16] ^ frame_w[i][15:8] ^ frame_w[i][7:0];
            end
            exp_err = bad;
            send_byte(len);
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    gap($urandom_range(0, max_gap));
                    send_byte(frame_w[i][31-8*j -: 8]);
                end
            end
            gap($urandom_range(0, max_gap));
            send_byte(x ^ {7'b0, bad});
        end
        wait_done();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        exp_err  = 1'b0;
        log_n    = 0;
        last_lat = 0;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {27'b0, in_ready, wr_en, busy, done, err}, 32'd0);
        @(posedge clk); #1;

        // Good two-word frame
        frame_w[0] = 32'h2001_0001;
        frame_w[1] = 32'h3022_0003;
        run_frame(8'h02, 1'b0, 0);
        check("t2_count", 32'(log_n), 32'd2);
        check("t2_word0", log_d[0], 32'h2001_0001);
        check("t2_word1", log_d[1], 32'h3022_0003);
        check("t2_addr1", {26'b0, log_a[1]}, 32'd1);
        check("t2_err", {31'b0, err}, 32'd0);

        // Same frame, checksum off by one bit
        run_frame(8'h02, 1'b1, 0);
        check("t3_count", 32'(log_n), 32'd2);
        check("t3_word1", log_d[1], 32'h3022_0003);
        check("t3_err_sticky", {31'b0, err}, 32'd1);

        // Oversized length
        run_frame(8'h41, 1'b0, 0);
        check("t4_no_writes", 32'(log_n), 32'd0);
        check("t4_done_latency", 32'(last_lat), 32'd1);
        check("t4_err", {31'b0, err}, 32'd1);

        // Full 64-word image with random valid gaps
        for (int i = 0; i < 64; i++) begin
            frame_w[i] = {8'(i), 8'(i) ^ 8'hA5, 8'h3C + 8'(i), ~8'(i)};
        end
        run_frame(8'h00, 1'b0, 3);
        check("t5_count", 32'(log_n), 32'd64);
        check("t5_word0", log_d[0], 32'h00A5_3CFF);
        check("t5_last_addr", {26'b0, log_a[63]}, 32'd63);
        check("t5_err", {31'b0, err}, 32'd0);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // Abort after five payload bytes
        frame_w[0] = 32'h1122_3344;
        frame_w[1] = 32'h5566_7788;
        log_n = 0;
        pulse_start();
        exp_err = 1'b1;
        exp_q.push_back(wr_t'{a: 6'd0, d: 32'h1122_3344});
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done();
        check("t6_count", 32'(log_n), 32'd1);
        check("t6_addr0", {26'b0, log_a[0]}, 32'd0);
        check("t6_word0", log_d[0], 32'h1122_3344);
        check("t6_err", {31'b0, err}, 32'd1);

        // Reset in the middle of a new frame
        pulse_start();
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t6_after_reset", {27'b0, in_ready, wr_en, busy, done, err}, 32'd0);
        @(posedge clk); #1;

        // Loader is usable again after the reset
        frame_w[0] = 32'hDEAD_BEEF;
        run_frame(8'h01, 1'b0, 1);
        check("t7_count", 32'(log_n), 32'd1);
        check("t7_addr0", {26'b0, log_a[0]}, 32'd0);
        check("t7_word0", log_d[0], 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
